// File: rtl/uart_byte_rx.sv
// ============================================================================
// Module  : uart_byte_rx -- 8N1 UART byte receiver with mid-bit sampling
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_serial_rx,
  output logic [7:0] data_rx,
  output logic       out_drive_rx,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic             sync_ff;
  logic             rx_s;
  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             hit_half;
  logic             hit_bit;
  logic             load_pulse;
  logic             err_pulse;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_ff <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync_ff <= in_serial_rx;
      rx_s    <= sync_ff;
    end
  end

  assign hit_half = (cnt == HALF_LAST);
  assign hit_bit  = (cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (!rx_s) state_next = S_START;
      S_START:     if (hit_half) state_next = rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (hit_bit && (bit_idx == 3'd7)) state_next = S_STOP;
      S_STOP:      if (hit_bit) state_next = rx_s ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_s) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    load_pulse = (state == S_STOP) && hit_bit && rx_s;
    err_pulse  = (state == S_STOP) && hit_bit && !rx_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      case (state)
        S_START: begin
          cnt     <= hit_half ? '0 : cnt + 1'b1;
          bit_idx <= 3'd0;
        end
        S_DATA: begin
          if (hit_bit) begin
            cnt                <= '0;
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: cnt <= hit_bit ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // Strobes are registered so each pulse lines up with the data_rx update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_rx      <= 8'h00;
      out_drive_rx <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      out_drive_rx <= load_pulse;
      frame_err    <= err_pulse;
      if (load_pulse) begin
        data_rx <= shift_reg;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
// ============================================================================
// Module  : tb_uart_byte_rx -- scoreboard bench for uart_byte_rx
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_byte_rx;

  localparam int CPB     = 16;
  localparam int PERIOD  = 10;
  localparam int LAT_MAX = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk          = 1'b0;
  logic       rst          = 1'b0;
  logic       in_serial_rx = 1'b1;
  logic [7:0] data_rx;
  logic       out_drive_rx;
  logic       frame_err;
  logic       busy;

  uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_serial_rx (in_serial_rx),
    .data_rx      (data_rx),
    .out_drive_rx (out_drive_rx),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #(PERIOD / 2) clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    longint     t0;
  } exp_t;

  exp_t       sbq[$];
  int         n_vec      = 0;
  int         n_miss     = 0;
  logic [7:0] model_data = 8'h00;
  longint     last_pulse_t = 0;
  longint     prev_pulse_t = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  initial begin
    exp_t   e;
    longint lat;
    forever begin
      @(negedge clk);
      if (out_drive_rx || frame_err) begin
        check("pulse_exclusive", longint'(out_drive_rx & frame_err), 0);
        if (sbq.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_pulse: got drive=%0b err=%0b, expected none (t=%0t)",
                   out_drive_rx, frame_err, $time);
        end else begin
          e   = sbq.pop_front();
          lat = ($time - e.t0) / PERIOD;
          check("pulse_kind_err", longint'(frame_err), longint'(e.is_err));
          if (e.is_err) begin
            check("data_held_on_err", longint'(data_rx), longint'(model_data));
          end else begin
            check("data_rx", longint'(data_rx), longint'(e.data));
            model_data = e.data;
          end
          n_vec++;
          if (lat > LAT_MAX) begin
            n_miss++;
            $display("FAIL latency: got %0d cycles, expected <= %0d", lat, LAT_MAX);
          end
          if (out_drive_rx) begin
            prev_pulse_t = last_pulse_t;
            last_pulse_t = $time;
          end
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    in_serial_rx = v;
    repeat (n) @(posedge clk);
  endtask

  // Reference model: an 8N1 frame yields its byte if the stop bit is high,
  // otherwise exactly one framing error.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    exp_t e;
    e.is_err = !stop_ok;
    e.data   = b;
    e.t0     = $time;
    sbq.push_back(e);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_ok, CPB);
    in_serial_rx = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_rx"}, longint'(data_rx), 0);
    check({tag, "_drive"},   longint'(out_drive_rx), 0);
    check({tag, "_ferr"},    longint'(frame_err), 0);
    check({tag, "_busy"},    longint'(busy), 0);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit         ok;
    int         gap;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    hold(1'b1, 4);

    send_frame(8'hA5, 1'b1);
    hold(1'b1, CPB);
    #1 check("a5_busy_idle", longint'(busy), 0);
    check("a5_data_rx", longint'(data_rx), 8'hA5);
    @(posedge clk);

    hold(1'b0, 4);
    #1 check("glitch_busy_start", longint'(busy), 1);
    @(posedge clk);
    hold(1'b1, 3 * CPB);
    #1 check("glitch_busy_idle", longint'(busy), 0);
    check("glitch_data_kept", longint'(data_rx), 8'hA5);
    @(posedge clk);

    send_frame(8'h3C, 1'b0);
    hold(1'b1, 2 * CPB);
    #1 check("ferr_busy_idle", longint'(busy), 0);
    check("ferr_data_kept", longint'(data_rx), 8'hA5);
    @(posedge clk);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    hold(1'b1, 2 * CPB);
    check("b2b_spacing", (last_pulse_t - prev_pulse_t) / PERIOD, 10 * CPB);
    check("b2b_data_rx", longint'(data_rx), 8'hFF);

    b = 8'h55;
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(b[i], CPB);
    hold(b[4], CPB / 2);
    rst          = 1'b0;
    in_serial_rx = 1'b1;
    model_data   = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("midframe_reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    hold(1'b1, 2 * CPB);
    send_frame(8'h81, 1'b1);
    hold(1'b1, CPB);
    #1 check("after_reset_data", longint'(data_rx), 8'h81);
    @(posedge clk);

    begin
      exp_t e;
      e.is_err = 1'b1;
      e.data   = 8'h00;
      e.t0     = $time;
      sbq.push_back(e);
    end
    hold(1'b0, 40 * CPB);
    #1 check("break_busy_low", longint'(busy), 1);
    @(posedge clk);
    hold(1'b1, CPB);
    #1 check("break_busy_idle", longint'(busy), 0);
    check("break_data_kept", longint'(data_rx), 8'h81);
    @(posedge clk);

    for (int k = 0; k < 24; k++) begin
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 4) != 0);
      gap = ok ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20));
      send_frame(b, ok);
      if (gap > 0) hold(1'b1, gap);
    end
    hold(1'b1, 3 * CPB);
    check("scoreboard_empty", longint'(sbq.size()), 0);
    #1 check("final_busy", longint'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
